// File: rtl/hold_toggle_bank.sv
// Multi-channel long-press detector and toggle bank for push-buttons.
// Optional auto-repeat of hold_pulse while held: define HOLD_TOGGLE_REPEAT_EN.
module hold_toggle_bank #(
    parameter int CHANNELS      = 4,
    parameter int frec_fpga     = 50000000,
    parameter int segundos      = 5,
    parameter int REPEAT_CYCLES = frec_fpga / 4,
    parameter int ACTIVE_LOW    = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] btn,
    input  logic [CHANNELS-1:0] clr_toggle,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] toggle_q,
    output logic [CHANNELS-1:0] hold_pulse,
    output logic [CHANNELS-1:0] short_pulse
);

    localparam int HOLD_CYCLES = frec_fpga * segundos;
`ifdef HOLD_TOGGLE_REPEAT_EN
    localparam int CNT_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
`else
    localparam int CNT_MAX = HOLD_CYCLES;
`endif
    localparam int CW = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] HOLD_VAL = CW'(HOLD_CYCLES);
`ifdef HOLD_TOGGLE_REPEAT_EN
    localparam logic [CW-1:0] REPEAT_VAL = CW'(REPEAT_CYCLES);
`endif
    // Synchroniser flops rest at the released pin level so reset never looks like a press
    localparam logic SYNC_IDLE = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HELD  = 2'd2
    } state_t;

    if (CHANNELS < 1 || HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_bad_cfg
        $error("hold_toggle_bank: CHANNELS must be >= 1, hold and repeat periods >= 2");
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic          r_sync1;
        logic          r_sync2;
        logic          r_pressed;
        state_t        r_state;
        logic [CW-1:0] r_cnt;
        logic          r_toggle;
        logic          r_hold;
        logic          r_short;
        logic          w_level;
        logic          w_flip;

        assign w_level = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
        assign w_flip  = (r_state == ST_COUNT) && r_pressed && (r_cnt == HOLD_VAL);

        // Two-flop synchroniser followed by the registered, polarity-normalised press level
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_sync1   <= SYNC_IDLE;
                r_sync2   <= SYNC_IDLE;
                r_pressed <= 1'b0;
            end else begin
                r_sync1   <= btn[i];
                r_sync2   <= r_sync1;
                r_pressed <= w_level;
            end
        end

        // Press-timing state machine with registered event pulses
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_state <= ST_IDLE;
                r_cnt   <= '0;
                r_hold  <= 1'b0;
                r_short <= 1'b0;
            end else begin
                r_hold  <= 1'b0;
                r_short <= 1'b0;
                case (r_state)
                    ST_IDLE: begin
                        if (r_pressed) begin
                            r_state <= ST_COUNT;
                            r_cnt   <= CW'(1'b1);
                        end else begin
                            r_cnt   <= '0;
                        end
                    end
                    ST_COUNT: begin
                        if (!r_pressed) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                            r_short <= 1'b1;
                        end else if (r_cnt == HOLD_VAL) begin
                            r_state <= ST_HELD;
                            r_cnt   <= '0;
                            r_hold  <= 1'b1;
                        end else begin
                            r_cnt   <= r_cnt + CW'(1'b1);
                        end
                    end
                    ST_HELD: begin
                        if (!r_pressed) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= '0;
                        end else begin
`ifdef HOLD_TOGGLE_REPEAT_EN
                            if (r_cnt == REPEAT_VAL) begin
                                r_cnt  <= '0;
                                r_hold <= 1'b1;
                            end else begin
                                r_cnt  <= r_cnt + CW'(1'b1);
                            end
`else
                            r_cnt <= '0;
`endif
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end

        // Toggle flag: a clear request beats a simultaneous threshold flip
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_toggle <= 1'b0;
            end else if (clr_toggle[i]) begin
                r_toggle <= 1'b0;
            end else if (w_flip) begin
                r_toggle <= ~r_toggle;
            end else begin
                r_toggle <= r_toggle;
            end
        end

        assign pressed[i]     = r_pressed;
        assign toggle_q[i]    = r_toggle;
        assign hold_pulse[i]  = r_hold;
        assign short_pulse[i] = r_short;
    end

endmodule

// File: tb/tb_hold_toggle_bank.sv
// Scoreboard bench for hold_toggle_bank: HOLD_CYCLES=10, two active-low channels.
module tb_hold_toggle_bank;

    localparam int CH = 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [CH-1:0] btn;
    logic [CH-1:0] clr_toggle;
    logic [CH-1:0] pressed;
    logic [CH-1:0] toggle_q;
    logic [CH-1:0] hold_pulse;
    logic [CH-1:0] short_pulse;

    always #5 clk = ~clk;

    hold_toggle_bank #(
        .CHANNELS      (CH),
        .frec_fpga     (10),
        .segundos      (1),
        .REPEAT_CYCLES (4),
        .ACTIVE_LOW    (1)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn         (btn),
        .clr_toggle  (clr_toggle),
        .pressed     (pressed),
        .toggle_q    (toggle_q),
        .hold_pulse  (hold_pulse),
        .short_pulse (short_pulse)
    );

    // Expected pulse event; hold=0 means short_pulse, tog is toggle_q in that cycle
    typedef struct {int cyc; int ch; bit hold; bit tog;} ev_t;
    // Expected level: kind 0 = all outputs zero, 1 = pressed[ch], 2 = toggle_q[ch]
    typedef struct {int cyc; int kind; int ch; bit exp;} lv_t;

    ev_t ev_q[$];
    lv_t lv_q[$];
    int  cyc      = 0;
    int  n_checks = 0;
    int  n_pass   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void push_ev(int c, int ch, bit h, bit t);
        ev_t e;
        e.cyc = c; e.ch = ch; e.hold = h; e.tog = t;
        ev_q.push_back(e);
    endfunction

    function automatic void push_lv(int c, int kind, int ch, bit x);
        lv_t l;
        l.cyc = c; l.kind = kind; l.ch = ch; l.exp = x;
        lv_q.push_back(l);
    endfunction

    task automatic go(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: compares every pulse and every scheduled level against the queues
    always @(negedge clk) begin
        ev_t  e;
        lv_t  l;
        logic got;
        while (ev_q.size() > 0 && ev_q[0].cyc < cyc) begin
            e = ev_q.pop_front();
            n_checks++;
            $display("FAIL missing_event ch%0d: no pulse seen, required hold=%0b at cyc=%0d",
                     e.ch, e.hold, e.cyc);
        end
        for (int ch = 0; ch < CH; ch++) begin
            if (hold_pulse[ch] && short_pulse[ch]) begin
                n_checks++;
                $display("FAIL both_pulses ch%0d cyc=%0d: got hold=1 short=1, required exclusive",
                         ch, cyc);
            end else if (hold_pulse[ch] || short_pulse[ch]) begin
                n_checks++;
                if (ev_q.size() == 0 || ev_q[0].cyc > cyc) begin
                    $display("FAIL unexpected_pulse ch%0d cyc=%0d: got hold=%0b short=%0b, required none",
                             ch, cyc, hold_pulse[ch], short_pulse[ch]);
                end else begin
                    e = ev_q.pop_front();
                    if (e.ch == ch && e.hold == hold_pulse[ch] && e.tog == toggle_q[ch]) begin
                        n_pass++;
                    end else begin
                        $display("FAIL event: got ch%0d cyc=%0d hold=%0b tog=%0b, required ch%0d cyc=%0d hold=%0b tog=%0b",
                                 ch, cyc, hold_pulse[ch], toggle_q[ch], e.ch, e.cyc, e.hold, e.tog);
                    end
                end
            end
        end
        while (lv_q.size() > 0 && lv_q[0].cyc <= cyc) begin
            l = lv_q.pop_front();
            n_checks++;
            case (l.kind)
                0:       got = ({pressed, toggle_q, hold_pulse, short_pulse} == 8'h00);
                1:       got = pressed[l.ch];
                default: got = toggle_q[l.ch];
            endcase
            if (l.cyc == cyc && got == l.exp) begin
                n_pass++;
            end else begin
                $display("FAIL level kind%0d ch%0d: got %0b at cyc=%0d, required %0b at cyc=%0d",
                         l.kind, l.ch, got, cyc, l.exp, l.cyc);
            end
        end
    end

    initial begin
        int c;
        int r;
        rst_n      = 1'b0;
        btn        = 2'b11;
        clr_toggle = 2'b00;
        push_lv(1, 0, 0, 1'b1);
        go(2);
        rst_n = 1'b1;
        go(3);

        // Long hold on ch0: pulse 13 edges after first low sample, toggle 0->1
        c = cyc;
        btn[0] = 1'b0;
        push_lv(c + 2, 1, 0, 1'b0);
        push_lv(c + 3, 1, 0, 1'b1);
        push_ev(c + 14, 0, 1'b1, 1'b1);
        go(20);
        btn[0] = 1'b1;
        go(8);

        // Press of exactly 10 cycles: short pulse only, toggle stays 1
        btn[0] = 1'b0;
        go(10);
        r = cyc;
        btn[0] = 1'b1;
        push_ev(r + 4, 0, 1'b0, 1'b1);
        push_lv(r + 5, 2, 0, 1'b1);
        go(10);

        // Second hold on ch0 (1->0) with ch1 hold offset by 3 cycles (0->1)
        c = cyc;
        btn[0] = 1'b0;
        push_ev(c + 14, 0, 1'b1, 1'b0);
        go(3);
        btn[1] = 1'b0;
        push_ev(c + 17, 1, 1'b1, 1'b1);
        go(20);
        btn = 2'b11;
        go(8);

        // Clear on the threshold edge: hold still fires, flip suppressed
        c = cyc;
        btn[0] = 1'b0;
        push_ev(c + 14, 0, 1'b1, 1'b0);
        go(13);
        clr_toggle[0] = 1'b1;
        go(1);
        clr_toggle[0] = 1'b0;
        go(10);
        btn[0] = 1'b1;
        go(8);

        // Standalone clear on an idle channel
        c = cyc;
        push_lv(c, 2, 1, 1'b1);
        push_lv(c + 1, 2, 1, 1'b0);
        clr_toggle[1] = 1'b1;
        go(1);
        clr_toggle[1] = 1'b0;
        go(2);

        // Reset at counter=7 while held; timing restarts after reset release
        c = cyc;
        btn[0] = 1'b0;
        go(10);
        rst_n = 1'b0;
        push_lv(c + 10, 0, 0, 1'b1);
        push_lv(c + 12, 0, 0, 1'b1);
        go(3);
        r = cyc;
        rst_n = 1'b1;
        push_ev(r + 14, 0, 1'b1, 1'b1);
        go(20);
        btn[0] = 1'b1;
        go(8);

        // Single-sample glitch on ch1 gives a short pulse
        c = cyc;
        btn[1] = 1'b0;
        go(1);
        btn[1] = 1'b1;
        push_ev(c + 5, 1, 1'b0, 1'b0);
        go(8);

        // 30-cycle hold on ch1: one flip, repeats every 5 cycles when enabled
        c = cyc;
        btn[1] = 1'b0;
        push_ev(c + 14, 1, 1'b1, 1'b1);
`ifdef HOLD_TOGGLE_REPEAT_EN
        push_ev(c + 19, 1, 1'b1, 1'b1);
        push_ev(c + 24, 1, 1'b1, 1'b1);
        push_ev(c + 29, 1, 1'b1, 1'b1);
`endif
        go(30);
        btn[1] = 1'b1;
        go(12);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
